// File: rtl/vdd_rail_sequencer.sv
// VDD rail power sequencer with an Avalon-MM register interface.
// Rails come up one at a time: a programmable delay, then the rail enable,
// then a wait for its power-good. Power-down runs in reverse order.
// A power-good timeout during power-up, or a lost power-good while fully on,
// drops every rail at once and holds the sequencer in FAULT until software
// clears it.
module vdd_rail_sequencer #(
   parameter int unsigned NUM_RAILS       = 5,
   parameter logic [15:0] DEFAULT_DELAY   = 16'd1000,
   parameter logic [15:0] DEFAULT_TIMEOUT = 16'd5000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic [NUM_RAILS-1:0] pgood,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic                 fault_irq
);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_UP_DLY = 3'd1,
      ST_UP_PG  = 3'd2,
      ST_ON     = 3'd3,
      ST_DN_DLY = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_RAILS - 1);

   state_t               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
   logic                 fault_q, fault_d;
   logic                 fault_irq_q, fault_irq_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 to_en_q, to_en_d;
   logic [15:0]          delay_q, delay_d;
   logic [15:0]          timeout_q, timeout_d;
   logic [NUM_RAILS-1:0] pg_meta_q;
   logic [NUM_RAILS-1:0] pg_sync_q;

   logic        wr_en;
   logic        ctrl_wr;
   logic        cmd_up;
   logic        cmd_dn;
   logic        cmd_clr;
   logic [15:0] dly_load;
   logic [15:0] cnt_dec;
   logic        cnt_last;
   logic        unused_wdata;

   // UP and DOWN in the same write resolve to DOWN
   assign wr_en    = chipselect & ~write_n;
   assign ctrl_wr  = wr_en & (address == 2'd0);
   assign cmd_dn   = ctrl_wr & writedata[1];
   assign cmd_up   = ctrl_wr & writedata[0] & ~writedata[1];
   assign cmd_clr  = ctrl_wr & writedata[2];

   // A zero delay still waits one cycle; counters saturate at zero
   assign dly_load = (delay_q == 16'd0) ? 16'd1 : delay_q;
   assign cnt_dec  = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
   assign cnt_last = (cnt_q <= 16'd1);

   assign unused_wdata = ^writedata[31:16];

   assign rail_en   = rail_en_q;
   assign fault_irq = fault_irq_q;

   // Zero-wait-state register read mux
   always_comb begin
      readdata = '0;
      case (address)
         2'd1: begin
            readdata[2:0]              = state_q;
            readdata[6:4]              = idx_q;
            readdata[8]                = fault_q;
            readdata[16 +: NUM_RAILS]  = pg_sync_q;
         end
         2'd2:    readdata[15:0] = delay_q;
         2'd3:    readdata[15:0] = timeout_q;
         default: readdata = '0;
      endcase
   end

   // Next-state, counter, rail-enable and register-write logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rail_en_d = rail_en_q;
      fault_d   = fault_q;
      cnt_d     = cnt_q;
      to_en_d   = to_en_q;
      delay_d   = delay_q;
      timeout_d = timeout_q;

      if (wr_en && address == 2'd2) begin
         delay_d = writedata[15:0];
      end
      if (wr_en && address == 2'd3) begin
         timeout_d = writedata[15:0];
      end

      case (state_q)
         ST_OFF: begin
            rail_en_d = '0;
            if (cmd_up) begin
               state_d = ST_UP_DLY;
               idx_d   = 3'd0;
               cnt_d   = dly_load;
            end
         end
         ST_UP_DLY: begin
            if (cmd_dn) begin
               // Current rail is not yet enabled: step back to the one below
               if (idx_q == 3'd0) begin
                  state_d = ST_OFF;
               end else begin
                  state_d = ST_DN_DLY;
                  idx_d   = idx_q - 3'd1;
                  cnt_d   = dly_load;
               end
            end else if (cnt_last) begin
               rail_en_d[idx_q] = 1'b1;
               state_d          = ST_UP_PG;
               cnt_d            = timeout_q;
               to_en_d          = (timeout_q != 16'd0);
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_UP_PG: begin
            if (cmd_dn) begin
               // Abort starts with the rail just enabled
               if (rail_en_q[idx_q]) begin
                  state_d = ST_DN_DLY;
                  cnt_d   = dly_load;
               end else if (idx_q == 3'd0) begin
                  state_d = ST_OFF;
               end else begin
                  state_d = ST_DN_DLY;
                  idx_d   = idx_q - 3'd1;
                  cnt_d   = dly_load;
               end
            end else if (pg_sync_q[idx_q]) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_ON;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_UP_DLY;
                  cnt_d   = dly_load;
               end
            end else if (to_en_q && cnt_last) begin
               state_d   = ST_FAULT;
               rail_en_d = '0;
               fault_d   = 1'b1;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_ON: begin
            if ((~pg_sync_q & rail_en_q) != '0) begin
               state_d   = ST_FAULT;
               rail_en_d = '0;
               fault_d   = 1'b1;
            end else if (cmd_dn) begin
               state_d = ST_DN_DLY;
               idx_d   = LAST_IDX;
               cnt_d   = dly_load;
            end
         end
         ST_DN_DLY: begin
            if (cnt_last) begin
               rail_en_d[idx_q] = 1'b0;
               if (idx_q == 3'd0) begin
                  state_d = ST_OFF;
               end else begin
                  idx_d = idx_q - 3'd1;
                  cnt_d = dly_load;
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_FAULT: begin
            rail_en_d = '0;
            if (cmd_clr) begin
               state_d = ST_OFF;
               fault_d = 1'b0;
               idx_d   = 3'd0;
            end
         end
         default: begin
            state_d   = ST_OFF;
            rail_en_d = '0;
         end
      endcase

      fault_irq_d = (state_d == ST_FAULT);
   end

   // State, counters, registers and the pgood synchronizer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_OFF;
         idx_q       <= 3'd0;
         rail_en_q   <= '0;
         fault_q     <= 1'b0;
         fault_irq_q <= 1'b0;
         cnt_q       <= 16'd0;
         to_en_q     <= 1'b0;
         delay_q     <= DEFAULT_DELAY;
         timeout_q   <= DEFAULT_TIMEOUT;
         pg_meta_q   <= '0;
         pg_sync_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rail_en_q   <= rail_en_d;
         fault_q     <= fault_d;
         fault_irq_q <= fault_irq_d;
         cnt_q       <= cnt_d;
         to_en_q     <= to_en_d;
         delay_q     <= delay_d;
         timeout_q   <= timeout_d;
         pg_meta_q   <= pgood;
         pg_sync_q   <= pg_meta_q;
      end
   end

endmodule

// File: tb/tb_vdd_rail_sequencer.sv
// Bench for vdd_rail_sequencer: a deadline-based behavioural model checked
// against the DUT every cycle, plus directed literal timing checks.
module tb_vdd_rail_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd1;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [4:0]  pgood;
   logic [4:0]  rail_en;
   logic        fault_irq;

   vdd_rail_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .pgood      (pgood),
      .rail_en    (rail_en),
      .fault_irq  (fault_irq)
   );

   always #5 clk = ~clk;

   // Supplies: pgood follows rail_en three half-cycles-to-cycles later, with a kill mask
   logic [4:0] h0 = '0, h1 = '0, h2 = '0;
   logic [4:0] pg_kill = '0;
   always @(negedge clk) begin
      h0 <= rail_en;
      h1 <= h0;
      h2 <= h1;
   end
   assign pgood = h2 & ~pg_kill;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int wcyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Behavioural model: modes use the STATUS codes, timing uses absolute deadlines
   typedef struct {
      int          mode;
      int          idx;
      logic [4:0]  en;
      bit          flt;
      int          due;
      bit          to_on;
      logic [15:0] dly;
      logic [15:0] tmo;
      logic [4:0]  r1;
      logic [4:0]  r2;
      int          now;
   } mdl_t;

   function automatic mdl_t mreset();
      mdl_t r;
      r.mode = 0; r.idx = 0; r.en = '0; r.flt = 0; r.due = 0; r.to_on = 0;
      r.dly = 16'd1000; r.tmo = 16'd5000; r.r1 = '0; r.r2 = '0; r.now = 0;
      return r;
   endfunction

   function automatic mdl_t step(mdl_t m, logic wr, logic [1:0] a, logic [31:0] wd, logic [4:0] pg);
      mdl_t n = m;
      logic [4:0] sy = m.r2;
      int wait_d = (m.dly == 16'd0) ? 1 : int'(m.dly);
      bit up  = wr && a == 2'd0 && wd[0] && !wd[1];
      bit dn  = wr && a == 2'd0 && wd[1];
      bit clr = wr && a == 2'd0 && wd[2];
      bit go_fault = 0;
      bit abort = 0;
      n.now = m.now + 1;
      case (m.mode)
         0: if (up) begin n.mode = 1; n.idx = 0; n.due = n.now + wait_d; end
         1: begin
            if (dn) abort = 1;
            else if (n.now == m.due) begin
               n.en[m.idx] = 1'b1; n.mode = 2;
               n.due = n.now + int'(m.tmo); n.to_on = (m.tmo != 0);
            end
         end
         2: begin
            if (dn) abort = 1;
            else if (sy[m.idx]) begin
               if (m.idx == 4) n.mode = 3;
               else begin n.idx = m.idx + 1; n.mode = 1; n.due = n.now + wait_d; end
            end else if (m.to_on && n.now == m.due) go_fault = 1;
         end
         3: begin
            if ((sy & m.en) != m.en) go_fault = 1;
            else if (dn) begin n.mode = 4; n.idx = 4; n.due = n.now + wait_d; end
         end
         4: if (n.now == m.due) begin
            n.en[m.idx] = 1'b0;
            if (m.idx == 0) n.mode = 0;
            else begin n.idx = m.idx - 1; n.due = n.now + wait_d; end
         end
         5: if (clr) begin n.mode = 0; n.flt = 0; n.idx = 0; end
         default: n.mode = 0;
      endcase
      if (abort) begin
         if (m.en[m.idx]) begin n.mode = 4; n.due = n.now + wait_d; end
         else if (m.idx == 0) n.mode = 0;
         else begin n.mode = 4; n.idx = m.idx - 1; n.due = n.now + wait_d; end
      end
      if (go_fault) begin n.mode = 5; n.en = '0; n.flt = 1; end
      if (wr && a == 2'd2) n.dly = wd[15:0];
      if (wr && a == 2'd3) n.tmo = wd[15:0];
      n.r2 = m.r1;
      n.r1 = pg;
      return n;
   endfunction

   function automatic logic [31:0] exp_read(mdl_t m, logic [1:0] a);
      logic [31:0] r = '0;
      case (a)
         2'd1: begin
            r[2:0]   = m.mode[2:0];
            r[6:4]   = m.idx[2:0];
            r[8]     = m.flt;
            r[20:16] = m.r2;
         end
         2'd2: r[15:0] = m.dly;
         2'd3: r[15:0] = m.tmo;
         default: r = '0;
      endcase
      return r;
   endfunction

   mdl_t m;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= mreset();
      else          m <= step(m, chipselect && !write_n, address, writedata, pgood);
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("mdl_rail_en", {27'd0, rail_en}, {27'd0, m.en});
      chk("mdl_fault_irq", {31'd0, fault_irq}, {31'd0, m.mode == 5});
      chk("mdl_readdata", readdata, exp_read(m, address));
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #2;
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      wcyc = cyc;
      #1;
      chipselect = 1'b0; write_n = 1'b1; address = 2'd1; writedata = 32'd0;
   endtask

   // Land on the falling edge after the k-th rising edge following the last write
   task automatic wait_until(input int k);
      while (cyc < wcyc + k) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
   endtask

   task automatic wait_state(input int code, input int idx, input int max_cyc, input string name);
      bit ok = 0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (readdata[2:0] == code[2:0] && (idx < 0 || readdata[6:4] == idx[2:0])) ok = 1;
      end
      chk(name, {31'd0, ok}, 32'd1);
   endtask

   task automatic st(input string name, input int code);
      chk(name, {29'd0, readdata[2:0]}, code);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_rail_en", {27'd0, rail_en}, 32'd0);
      chk("rst_irq", {31'd0, fault_irq}, 32'd0);
      chk("rst_status", readdata, 32'd0);
      address = 2'd2; #1 chk("rst_delay", readdata, 32'd1000);
      address = 2'd3; #1 chk("rst_timeout", readdata, 32'd5000);
      address = 2'd1;

      // Power-up with DELAY=4, TIMEOUT=100
      wr(2'd2, 32'd4);
      wr(2'd3, 32'd100);
      wr(2'd0, 32'd1);
      $display("txn: UP with DELAY=4 TIMEOUT=100");
      wait_until(3);  chk("up_c3", {27'd0, rail_en}, 32'b00000);
      wait_until(4);  chk("up_c4", {27'd0, rail_en}, 32'b00001); st("up_c4_st", 2);
      wait_until(13); chk("up_c13", {27'd0, rail_en}, 32'b00011);
      wait_until(40); chk("up_c40", {27'd0, rail_en}, 32'b11111);
      wait_until(44); st("up_c44_st", 2);
      wait_until(45); st("up_on_st", 3);

      // Power-down from ON
      wr(2'd0, 32'd2);
      $display("txn: DOWN from ON");
      wait_until(4);  chk("dn_c4", {27'd0, rail_en}, 32'b01111);
      wait_until(8);  chk("dn_c8", {27'd0, rail_en}, 32'b00111);
      wait_until(12); chk("dn_c12", {27'd0, rail_en}, 32'b00011);
      wait_until(16); chk("dn_c16", {27'd0, rail_en}, 32'b00001);
      wait_until(20); chk("dn_c20", {27'd0, rail_en}, 32'b00000); st("dn_off_st", 0);

      // Power-good timeout on rail 2
      wr(2'd3, 32'd10);
      pg_kill = 5'b00100;
      wr(2'd0, 32'd1);
      $display("txn: UP with pgood[2] stuck low, TIMEOUT=10");
      wait_until(22); chk("to_c22", {27'd0, rail_en}, 32'b00111); st("to_c22_st", 2);
      wait_until(31); chk("to_c31", {27'd0, rail_en}, 32'b00111);
      chk("to_c31_irq", {31'd0, fault_irq}, 32'd0);
      wait_until(32); chk("to_c32", {27'd0, rail_en}, 32'd0);
      chk("to_c32_irq", {31'd0, fault_irq}, 32'd1); st("to_c32_st", 5);
      chk("to_fault_bit", {31'd0, readdata[8]}, 32'd1);
      wr(2'd0, 32'd1);
      @(negedge clk); st("fault_up_ignored", 5);
      wr(2'd0, 32'd4);
      $display("txn: CLR_FAULT");
      @(negedge clk); st("clr_st", 0); chk("clr_irq", {31'd0, fault_irq}, 32'd0);
      pg_kill = '0;

      // Lost pgood while ON: 3-cycle pulse, then 1-cycle glitch
      wr(2'd3, 32'd100);
      wr(2'd0, 32'd1);
      wait_state(3, -1, 80, "on_reached_a");
      @(posedge clk); #2 pg_kill = 5'b01000;
      repeat (3) @(posedge clk);
      #2 pg_kill = '0;
      $display("txn: pgood[3] low for 3 cycles in ON");
      @(negedge clk);
      chk("pulse_irq", {31'd0, fault_irq}, 32'd1);
      chk("pulse_rail_en", {27'd0, rail_en}, 32'd0);
      wr(2'd0, 32'd4);
      wr(2'd0, 32'd1);
      wait_state(3, -1, 80, "on_reached_b");
      @(posedge clk); #2 pg_kill = 5'b01000;
      @(posedge clk); #2 pg_kill = '0;
      $display("txn: pgood[3] 1-cycle glitch in ON");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("glitch_irq", {31'd0, fault_irq}, 32'd1);
      chk("glitch_rail_en", {27'd0, rail_en}, 32'd0);
      wr(2'd0, 32'd4);

      // Abort during UP_PG at idx 2
      wr(2'd0, 32'd1);
      wait_state(2, 2, 60, "pg_idx2_reached");
      wr(2'd0, 32'd2);
      $display("txn: DOWN during UP_PG idx=2");
      wait_until(4);  chk("ab_c4", {27'd0, rail_en}, 32'b00011);
      wait_until(8);  chk("ab_c8", {27'd0, rail_en}, 32'b00001);
      wait_until(12); chk("ab_c12", {27'd0, rail_en}, 32'b00000);
      st("ab_off_st", 0); chk("ab_irq", {31'd0, fault_irq}, 32'd0);

      // DELAY=0 acts as one cycle; TIMEOUT=0 never faults
      wr(2'd2, 32'd0);
      wr(2'd3, 32'd0);
      pg_kill = 5'b00001;
      wr(2'd0, 32'd1);
      $display("txn: UP with DELAY=0 TIMEOUT=0, pgood[0] held low");
      wait_until(0);  st("z_c0_st", 1); chk("z_c0", {27'd0, rail_en}, 32'd0);
      wait_until(1);  st("z_c1_st", 2); chk("z_c1", {27'd0, rail_en}, 32'b00001);
      wait_until(40); st("z_c40_st", 2); chk("z_c40_irq", {31'd0, fault_irq}, 32'd0);
      wr(2'd0, 32'd2);
      wait_until(0);  st("z_dn_st", 4); chk("z_dn", {27'd0, rail_en}, 32'b00001);
      wait_until(1);  st("z_off_st", 0); chk("z_off", {27'd0, rail_en}, 32'd0);
      pg_kill = '0;

      // Abort in UP_DLY idx 0, then ignored commands in OFF
      wr(2'd2, 32'd4);
      wr(2'd0, 32'd1);
      wr(2'd0, 32'd2);
      $display("txn: DOWN during UP_DLY idx=0");
      @(negedge clk); st("abdly_st", 0);
      wr(2'd0, 32'd3);
      $display("txn: UP+DOWN together in OFF");
      @(negedge clk); st("updn_st", 0);

      // Asynchronous reset in UP_DLY idx 3
      wr(2'd3, 32'd100);
      wr(2'd0, 32'd1);
      wait_state(1, 3, 80, "updly3_reached");
      chk("pre_rst_rail_en", {27'd0, rail_en}, 32'b00111);
      @(posedge clk); #2 reset_n = 1'b0;
      $display("txn: reset_n asserted in UP_DLY idx=3");
      #1 chk("arst_rail_en", {27'd0, rail_en}, 32'd0);
      chk("arst_irq", {31'd0, fault_irq}, 32'd0);
      address = 2'd2; #1 chk("arst_delay", readdata, 32'd1000);
      address = 2'd3; #1 chk("arst_timeout", readdata, 32'd5000);
      address = 2'd1; #1 chk("arst_status", readdata, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_rail_en", {27'd0, rail_en}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
